sram_ctrl: RTL and testbench

- Synchronous initiator for the team's asynchronous SRAM chip model: chip-select, write-enable and output-enable are all active-low, and the chip has a bidirectional data bus.
- Converts single-word host requests (valid/ready) into correctly sequenced SRAM strobe cycles.
- Guarantees setup/hold ordering of address, data, CS, WE and OE.
- Sits between a CPU/DMA master and the SRAM chip instance.

---
 rtl/sram_ctrl_pkg.sv | 23 ++
 rtl/sram_wait_timer.sv | 41 ++++
 rtl/sram_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_sram_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared definitions for the SRAM initiator.
//   state_e         - controller state encoding (V* states only reachable
//                     when SRAM_CTRL_WRITE_VERIFY_EN is defined)
//   STROBE_OFF      - inactive level of the active-low SRAM strobes
//   WAIT_STATES_MAX - largest supported WaitStates value
//   TIMER_W         - width of the strobe timer needed for WAIT_STATES_MAX
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_STROBE  = 3'd2,
        ST_HOLD    = 3'd3,
        ST_VSETUP  = 3'd4,
        ST_VSTROBE = 3'd5,
        ST_VHOLD   = 3'd6
    } state_e;

    localparam logic STROBE_OFF      = 1'b1;
    localparam int   WAIT_STATES_MAX = 15;
    localparam int   TIMER_W         = $clog2(WAIT_STATES_MAX + 1);

endpackage

// File: rtl/sram_wait_timer.sv
// sram_wait_timer: loadable down-counter that times the strobe-low phase.
//   clk_i        - clock
//   rst_i        - synchronous active-high reset (count cleared to 0)
//   load_i       - load load_value_i on the next edge
//   load_value_i - start value; the strobe phase lasts load_value_i+1 cycles
//   tc_o         - terminal count, high while the count is zero
module sram_wait_timer
    import sram_ctrl_pkg::*;
#(
    parameter int Width = TIMER_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_value_i,
    output logic             tc_o
);

    logic [Width-1:0] count_q;
    logic [Width-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_value_i;
        end else if (count_q != '0) begin
            count_d = count_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc_o = (count_q == '0);

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: synchronous initiator for an asynchronous SRAM with active-low
// CS/WE/OE and a bidirectional data bus. Each accepted host request becomes
// SETUP (1 cycle) -> STROBE (WaitStates+1 cycles) -> HOLD (1 cycle).
//
// Optional feature: define SRAM_CTRL_WRITE_VERIFY_EN to follow every write
// with a read-back of the same address (VSETUP/VSTROBE/VHOLD); a mismatch
// pulses VerifyError. Without it VerifyError is tied low.
//
// Ports:
//   Clk, Reset            - clock, synchronous active-high reset
//   ReqValid/ReqReady     - host handshake; ReqReady high only in IDLE
//   ReqWrite/ReqAddress/ReqData - request fields (1 = write)
//   RspValid/RspData      - read response pulse; data held until next read
//   VerifyError           - write-verify mismatch pulse
//   Address, Data         - SRAM address and bidirectional data bus
//   CS, WE, OE            - SRAM strobes, active-low, all registered
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int AddressSize = 1,
    parameter int WordSize    = 1,
    parameter int WaitStates  = 1
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   ReqValid,
    output logic                   ReqReady,
    input  logic                   ReqWrite,
    input  logic [AddressSize-1:0] ReqAddress,
    input  logic [WordSize-1:0]    ReqData,
    output logic                   RspValid,
    output logic [WordSize-1:0]    RspData,
    output logic                   VerifyError,
    output logic [AddressSize-1:0] Address,
    inout  wire  [WordSize-1:0]    Data,
    output logic                   CS,
    output logic                   WE,
    output logic                   OE
);

    localparam logic [TIMER_W-1:0] WAIT_LOAD = TIMER_W'(WaitStates);

    state_e                   state_q, state_d;
    logic [AddressSize-1:0]   addr_q;
    logic [WordSize-1:0]      wdata_q;
    logic                     write_q;
    logic                     cs_q, cs_d;
    logic                     we_q, we_d;
    logic                     oe_q, oe_d;
    logic                     drive_q, drive_d;
    logic                     ready_q;
    logic                     rsp_valid_q;
    logic [WordSize-1:0]      rsp_data_q;

    logic accept;
    logic wr_next;
    logic timer_load;
    logic timer_tc;
    logic read_done;

    assign accept  = ReqValid && ready_q;
    // Write flag as it will be after this edge, so the registered strobes
    // for SETUP/STROBE already reflect a request being accepted right now.
    assign wr_next = accept ? ReqWrite : write_q;

    // The timer is loaded during SETUP/VSETUP so it holds WaitStates on the
    // first strobe cycle and reaches zero on the last one.
    assign timer_load = (state_q == ST_SETUP) || (state_q == ST_VSETUP);
    assign read_done  = (state_q == ST_STROBE) && timer_tc && !write_q;

    sram_wait_timer #(
        .Width(TIMER_W)
    ) u_timer (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .load_i      (timer_load),
        .load_value_i(WAIT_LOAD),
        .tc_o        (timer_tc)
    );

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SETUP;
            ST_SETUP:  state_d = ST_STROBE;
            ST_STROBE: if (timer_tc) state_d = ST_HOLD;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
            ST_HOLD:    state_d = write_q ? ST_VSETUP : ST_IDLE;
            ST_VSETUP:  state_d = ST_VSTROBE;
            ST_VSTROBE: if (timer_tc) state_d = ST_VHOLD;
            ST_VHOLD:   state_d = ST_IDLE;
`else
            ST_HOLD:    state_d = ST_IDLE;
`endif
            default:   state_d = ST_IDLE;
        endcase
    end

    // SRAM pin values for the state being entered; registered below so the
    // pins change only on clock edges and always match state_q.
    always_comb begin
        cs_d    = STROBE_OFF;
        we_d    = STROBE_OFF;
        oe_d    = STROBE_OFF;
        drive_d = 1'b0;
        case (state_d)
            ST_SETUP, ST_HOLD: drive_d = wr_next;
            ST_STROBE: begin
                cs_d    = ~STROBE_OFF;
                drive_d = wr_next;
                if (wr_next) begin
                    we_d = ~STROBE_OFF;
                end else begin
                    oe_d = ~STROBE_OFF;
                end
            end
            ST_VSTROBE: begin
                cs_d = ~STROBE_OFF;
                oe_d = ~STROBE_OFF;
            end
            default: ;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            cs_q        <= STROBE_OFF;
            we_q        <= STROBE_OFF;
            oe_q        <= STROBE_OFF;
            drive_q     <= 1'b0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cs_q        <= cs_d;
            we_q        <= we_d;
            oe_q        <= oe_d;
            drive_q     <= drive_d;
            ready_q     <= (state_d == ST_IDLE);
            rsp_valid_q <= read_done;
            if (accept) begin
                addr_q  <= ReqAddress;
                wdata_q <= ReqData;
                write_q <= ReqWrite;
            end
            // Sample on the final strobe edge, while OE is still low.
            if (read_done) begin
                rsp_data_q <= Data;
            end
        end
    end

`ifdef SRAM_CTRL_WRITE_VERIFY_EN
    logic verify_err_q;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            verify_err_q <= 1'b0;
        end else begin
            verify_err_q <= (state_q == ST_VSTROBE) && timer_tc && (Data != wdata_q);
        end
    end

    assign VerifyError = verify_err_q;
`else
    assign VerifyError = 1'b0;
`endif

    assign Data     = drive_q ? wdata_q : 'z;
    assign Address  = addr_q;
    assign CS       = cs_q;
    assign WE       = we_q;
    assign OE       = oe_q;
    assign ReqReady = ready_q;
    assign RspValid = rsp_valid_q;
    assign RspData  = rsp_data_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed bench for sram_ctrl. Three controllers share one
// clock, reset and request fields (WaitStates 1, 0 and 15), each with its own
// ReqValid and its own behavioural asynchronous SRAM.
module tb_sram_ctrl;

    localparam int AW  = 4;
    localparam int DW  = 8;
    localparam int WS0 = 1;
    localparam int WS1 = 0;
    localparam int WS2 = 15;
`ifdef SRAM_CTRL_WRITE_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              srst;
    logic [2:0]        rv, rdy, rsp_v, verr, cs_n, we_n, oe_n;
    logic              req_write;
    logic [AW-1:0]     req_addr;
    logic [DW-1:0]     req_data;
    logic [2:0][DW-1:0] rsp_d;
    logic [2:0][AW-1:0] sram_addr;
    wire  [DW-1:0]     bus0, bus1, bus2;
    logic [DW-1:0]     mem0 [16];
    logic [DW-1:0]     mem1 [16];
    logic [DW-1:0]     mem2 [16];
    logic              corrupt;
    logic              mon_en;
    logic [DW-1:0]     shadow [16];
    logic [DW-1:0]     rsp_log [$];
    int                checks = 0;
    int                errors = 0;
    int                cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    sram_ctrl #(.AddressSize(AW), .WordSize(DW), .WaitStates(WS0)) u_dut0 (
        .Clk(clk), .Reset(srst), .ReqValid(rv[0]), .ReqReady(rdy[0]),
        .ReqWrite(req_write), .ReqAddress(req_addr), .ReqData(req_data),
        .RspValid(rsp_v[0]), .RspData(rsp_d[0]), .VerifyError(verr[0]),
        .Address(sram_addr[0]), .Data(bus0), .CS(cs_n[0]), .WE(we_n[0]), .OE(oe_n[0]));

    sram_ctrl #(.AddressSize(AW), .WordSize(DW), .WaitStates(WS1)) u_dut1 (
        .Clk(clk), .Reset(srst), .ReqValid(rv[1]), .ReqReady(rdy[1]),
        .ReqWrite(req_write), .ReqAddress(req_addr), .ReqData(req_data),
        .RspValid(rsp_v[1]), .RspData(rsp_d[1]), .VerifyError(verr[1]),
        .Address(sram_addr[1]), .Data(bus1), .CS(cs_n[1]), .WE(we_n[1]), .OE(oe_n[1]));

    sram_ctrl #(.AddressSize(AW), .WordSize(DW), .WaitStates(WS2)) u_dut2 (
        .Clk(clk), .Reset(srst), .ReqValid(rv[2]), .ReqReady(rdy[2]),
        .ReqWrite(req_write), .ReqAddress(req_addr), .ReqData(req_data),
        .RspValid(rsp_v[2]), .RspData(rsp_d[2]), .VerifyError(verr[2]),
        .Address(sram_addr[2]), .Data(bus2), .CS(cs_n[2]), .WE(we_n[2]), .OE(oe_n[2]));

    // SRAM models: drive the bus while selected with OE low; store while WE low.
    // 'corrupt' makes chip 0 return 0x00 on every read.
    assign bus0 = (!cs_n[0] && !oe_n[0]) ? (corrupt ? 8'h00 : mem0[sram_addr[0]]) : 8'hzz;
    assign bus1 = (!cs_n[1] && !oe_n[1]) ? mem1[sram_addr[1]] : 8'hzz;
    assign bus2 = (!cs_n[2] && !oe_n[2]) ? mem2[sram_addr[2]] : 8'hzz;

    always @(posedge clk) begin
        if (!cs_n[0] && !we_n[0]) mem0[sram_addr[0]] <= bus0;
        if (!cs_n[1] && !we_n[1]) mem1[sram_addr[1]] <= bus1;
        if (!cs_n[2] && !we_n[2]) mem2[sram_addr[2]] <= bus2;
    end

    function automatic logic [DW-1:0] bus_of(input int s);
        case (s)
            0:       return bus0;
            1:       return bus1;
            default: return bus2;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Protocol monitor
    logic [2:0][AW-1:0] prev_addr;
    logic [2:0][DW-1:0] prev_bus;
    always @(negedge clk) begin
        if (mon_en) begin
            for (int s = 0; s < 3; s++) begin
                check("we_oe_exclusive", {31'd0, !(!we_n[s] && !oe_n[s])}, 32'd1);
                check("strobe_needs_cs", {31'd0, !((!we_n[s] || !oe_n[s]) && cs_n[s])}, 32'd1);
                if (!cs_n[s]) check("addr_stable", {28'd0, sram_addr[s]}, {28'd0, prev_addr[s]});
                if (!we_n[s]) check("data_stable", {24'd0, bus_of(s)}, {24'd0, prev_bus[s]});
            end
            if (rsp_v[0]) rsp_log.push_back(rsp_d[0]);
        end
        for (int s = 0; s < 3; s++) begin
            prev_addr[s] <= sram_addr[s];
            prev_bus[s]  <= bus_of(s);
        end
    end

    // One access on controller s, started and finished on a falling edge.
    // k counts falling edges after the accept edge (k=1 is the SETUP cycle).
    task automatic access(input int s, input bit wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, output logic [DW-1:0] rd,
                          output int lat, output int we_cnt, output int oe_cnt,
                          output int done_k, output int rsp_cnt, output int verr_cnt);
        int t;
        rd = '0; lat = -1; we_cnt = 0; oe_cnt = 0; done_k = -1; rsp_cnt = 0; verr_cnt = 0;
        rv[s] = 1'b1; req_write = wr; req_addr = a; req_data = d;
        t = 0;
        while (!rdy[s] && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            check("accept_timeout", 32'(t), 32'd0);
            rv[s] = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        rv[s] = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            if (rdy[s]) begin
                done_k = k;
                break;
            end
            if (!we_n[s]) we_cnt++;
            if (!oe_n[s]) oe_cnt++;
            if (verr[s]) verr_cnt++;
            if (rsp_v[s]) begin
                rsp_cnt++;
                if (lat < 0) lat = k;
                rd = rsp_d[s];
            end
            @(negedge clk);
        end
        $display("tb: inst=%0d %s addr=0x%0h wdata=0x%0h rdata=0x%0h lat=%0d we=%0d oe=%0d done=%0d verr=%0d",
                 s, wr ? "WR" : "RD", a, d, rd, lat, we_cnt, oe_cnt, done_k, verr_cnt);
    endtask

    initial begin
        logic [DW-1:0] rd;
        int lat, we_c, oe_c, done_k, rsp_c, verr_c, t;
        int acc [4];
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        bit wr;

        srst = 1'b1; rv = '0; req_write = 1'b0; req_addr = '0; req_data = '0;
        corrupt = 1'b0; mon_en = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_strobes", {23'd0, cs_n, we_n, oe_n}, 32'h1FF);
        check("rst_ready", {29'd0, rdy}, 32'd0);
        check("rst_rspvalid", {29'd0, rsp_v}, 32'd0);
        check("rst_rspdata", {8'd0, rsp_d}, 32'd0);
        check("rst_addr", {20'd0, sram_addr}, 32'd0);
        check("rst_verr", {29'd0, verr}, 32'd0);
        srst = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("ready_after_rst", {29'd0, rdy}, 32'h7);

        // Write 0xA5 to 3, read it back (WaitStates=1)
        access(0, 1'b1, 4'h3, 8'hA5, rd, lat, we_c, oe_c, done_k, rsp_c, verr_c);
        shadow[3] = 8'hA5;
        check("wr_we_width", 32'(we_c), 32'(WS0 + 1));
        check("wr_no_rsp", 32'(rsp_c), 32'd0);
        check("wr_done", 32'(done_k), VERIFY ? 32'(2 * WS0 + 7) : 32'(WS0 + 4));
        check("wr_verr", 32'(verr_c), 32'd0);
        access(0, 1'b0, 4'h3, 8'h00, rd, lat, we_c, oe_c, done_k, rsp_c, verr_c);
        check("rd_data", {24'd0, rd}, 32'hA5);
        check("rd_latency", 32'(lat), 32'(WS0 + 3));
        check("rd_oe_width", 32'(oe_c), 32'(WS0 + 1));
        check("rd_no_we", 32'(we_c), 32'd0);
        check("rd_one_pulse", 32'(rsp_c), 32'd1);
        check("rd_done", 32'(done_k), 32'(WS0 + 4));

        // RspData held across idle cycles and a write
        repeat (3) @(negedge clk);
        access(0, 1'b1, 4'h4, 8'h11, rd, lat, we_c, oe_c, done_k, rsp_c, verr_c);
        shadow[4] = 8'h11;
        check("rspdata_hold", {24'd0, rsp_d[0]}, 32'hA5);

        // WaitStates=0: one-cycle strobes, address 0
        access(1, 1'b1, 4'h0, 8'h3C, rd, lat, we_c, oe_c, done_k, rsp_c, verr_c);
        check("ws0_we_width", 32'(we_c), 32'd1);
        access(1, 1'b0, 4'h0, 8'h00, rd, lat, we_c, oe_c, done_k, rsp_c, verr_c);
        check("ws0_rd_data", {24'd0, rd}, 32'h3C);
        check("ws0_oe_width", 32'(oe_c), 32'd1);
        check("ws0_latency", 32'(lat), 32'd3);

        // WaitStates=15: sixteen-cycle strobes, top address
        access(2, 1'b1, 4'hF, 8'hC3, rd, lat, we_c, oe_c, done_k, rsp_c, verr_c);
        check("ws15_we_width", 32'(we_c), 32'd16);
        access(2, 1'b0, 4'hF, 8'h00, rd, lat, we_c, oe_c, done_k, rsp_c, verr_c);
        check("ws15_rd_data", {24'd0, rd}, 32'hC3);
        check("ws15_oe_width", 32'(oe_c), 32'd16);
        check("ws15_latency", 32'(lat), 32'd18);
        check("ws15_addr_passthru", {28'd0, sram_addr[2]}, 32'hF);

        // Back-to-back: fill 8..11, then hold ReqValid for four reads
        for (int i = 0; i < 4; i++) begin
            access(0, 1'b1, 4'(8 + i), 8'(8'h60 + i * 8'h11), rd, lat, we_c, oe_c, done_k, rsp_c, verr_c);
            shadow[8 + i] = 8'(8'h60 + i * 8'h11);
        end
        rsp_log.delete();
        rv[0] = 1'b1; req_write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            req_addr = 4'(8 + i);
            t = 0;
            while (!rdy[0] && t < 20) begin
                @(negedge clk);
                t++;
            end
            acc[i] = cyc;
            @(posedge clk);
            @(negedge clk);
        end
        rv[0] = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 1; i < 4; i++) check("b2b_spacing", 32'(acc[i] - acc[i - 1]), 32'(WS0 + 4));
        check("b2b_rsp_count", 32'(rsp_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < rsp_log.size(); i++)
            check("b2b_rsp_order", {24'd0, rsp_log[i]}, {24'd0, shadow[8 + i]});

        // Random accesses: write every address first, then mix
        for (int i = 0; i < 200; i++) begin
            a  = (i < 16) ? 4'(i) : 4'($urandom_range(0, 15));
            d  = 8'($urandom_range(0, 255));
            wr = (i < 16) ? 1'b1 : 1'($urandom_range(0, 1));
            access(0, wr, a, d, rd, lat, we_c, oe_c, done_k, rsp_c, verr_c);
            if (wr) shadow[a] = d;
            else    check("rand_rd_data", {24'd0, rd}, {24'd0, shadow[a]});
        end

        // Reset in the second STROBE cycle of a read
        rsp_log.delete();
        rv[0] = 1'b1; req_write = 1'b0; req_addr = 4'h3;
        t = 0;
        while (!rdy[0] && t < 20) begin
            @(negedge clk);
            t++;
        end
        @(posedge clk);
        @(negedge clk);
        rv[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_in_strobe", {31'd0, oe_n[0]}, 32'd0);
        srst = 1'b1;
        @(negedge clk);
        check("midrst_strobes", {30'd0, cs_n[0], oe_n[0]}, 32'h3);
        check("midrst_rspvalid", {31'd0, rsp_v[0]}, 32'd0);
        check("midrst_ready_low", {31'd0, rdy[0]}, 32'd0);
        srst = 1'b0;
        @(negedge clk);
        check("midrst_ready", {31'd0, rdy[0]}, 32'd1);
        repeat (6) @(negedge clk);
        check("midrst_no_rsp", 32'(rsp_log.size()), 32'd0);

        // Write verify: failing chip, then healthy chip
        corrupt = 1'b1;
        access(0, 1'b1, 4'h5, 8'h5A, rd, lat, we_c, oe_c, done_k, rsp_c, verr_c);
        corrupt = 1'b0;
        shadow[5] = 8'h5A;
        check("verify_bad_pulses", 32'(verr_c), VERIFY ? 32'd1 : 32'd0);
        check("verify_bad_no_rsp", 32'(rsp_c), 32'd0);
        check("verify_wr_done", 32'(done_k), VERIFY ? 32'(2 * WS0 + 7) : 32'(WS0 + 4));
        access(0, 1'b1, 4'h5, 8'h5A, rd, lat, we_c, oe_c, done_k, rsp_c, verr_c);
        check("verify_good_pulses", 32'(verr_c), 32'd0);
        access(0, 1'b0, 4'h5, 8'h00, rd, lat, we_c, oe_c, done_k, rsp_c, verr_c);
        check("verify_rd_data", {24'd0, rd}, 32'h5A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
